// File: rtl/skintone_pkg.sv
// skintone_pkg: shared BT.601 coefficients, offsets, clamp limits and framing types
// Used by rgb_to_ycbcr and the downstream width/centre stages.
package skintone_pkg;
  localparam int C_YR  = 66;
  localparam int C_YG  = 129;
  localparam int C_YB  = 25;
  localparam int C_CBR = -38;
  localparam int C_CBG = -74;
  localparam int C_CBB = 112;
  localparam int C_CRR = 112;
  localparam int C_CRG = -94;
  localparam int C_CRB = -18;
  localparam int OFS_Y = 4224;
  localparam int OFS_C = 32896;
  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;
  localparam logic [7:0] C_MIN = 8'd16;
  localparam logic [7:0] C_MAX = 8'd240;
  typedef enum logic {WAIT_SOF, ACTIVE} frame_state_t;
  function automatic logic [7:0] clamp8(input logic signed [17:0] acc, input logic [7:0] lo, input logic [7:0] hi);
    logic signed [17:0] v;
    v = acc >>> 8;
    return v < $signed({10'd0, lo}) ? lo : v > $signed({10'd0, hi}) ? hi : v[7:0];
  endfunction
endpackage

// File: rtl/rgb_to_ycbcr_if.sv
// rgb_to_ycbcr_if: RGB pixel stream in, framed Y/Cb/Cr stream out
// master drives r/g/b/pix_valid/sof_in and observes the converted stream; slave is the converter.
interface rgb_to_ycbcr_if;
  logic [7:0] r, g, b;
  logic       pix_valid, sof_in;
  logic [7:0] y, cb, cr;
  logic       y_valid, sof, eol, eof, frame_err;
  modport master(output r, g, b, pix_valid, sof_in, input y, cb, cr, y_valid, sof, eol, eof, frame_err);
  modport slave(input r, g, b, pix_valid, sof_in, output y, cb, cr, y_valid, sof, eol, eof, frame_err);
endinterface

// File: rtl/rgb_to_ycbcr_dot3.sv
// csc_dot3: signed 3-term multiply-accumulate plus offset, products at S1, sum at S2
// Ports: clk, rst (async active-low), a/b/c unsigned 8-bit terms, acc signed 18-bit result.
module csc_dot3 #(
  parameter int K0  = 0,
  parameter int K1  = 0,
  parameter int K2  = 0,
  parameter int OFS = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [7:0]         c,
  output logic signed [17:0] acc
);
  logic signed [17:0] p0, p1, p2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p0  <= '0;
      p1  <= '0;
      p2  <= '0;
      acc <= '0;
    end else begin
      p0  <= $signed({10'd0, a}) * 18'(K0);
      p1  <= $signed({10'd0, b}) * 18'(K1);
      p2  <= $signed({10'd0, c}) * 18'(K2);
      acc <= p0 + p1 + p2 + 18'(OFS);
    end
endmodule

// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: 3-stage BT.601 RGB to Y/Cb/Cr converter with frame alignment
// Ports: clk, rst (async active-low), px (slave modport: pixel stream in, tagged Y/Cb/Cr out).
module rgb_to_ycbcr import skintone_pkg::*; #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic           clk,
  input logic           rst,
  rgb_to_ycbcr_if.slave px
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  frame_state_t       state;
  logic               done;
  logic [CW-1:0]      col, cur_col;
  logic [RW-1:0]      row, cur_row;
  logic               acc_ok, last_col, at_eol, at_eof;
  logic [1:0]         v, ts, te, tf;
  logic signed [17:0] acc_y, acc_cb, acc_cr;
  csc_dot3 #(.K0(C_YR), .K1(C_YG), .K2(C_YB), .OFS(OFS_Y)) u_y (
    .clk(clk), .rst(rst), .a(px.r), .b(px.g), .c(px.b), .acc(acc_y));
  csc_dot3 #(.K0(C_CBR), .K1(C_CBG), .K2(C_CBB), .OFS(OFS_C)) u_cb (
    .clk(clk), .rst(rst), .a(px.r), .b(px.g), .c(px.b), .acc(acc_cb));
  csc_dot3 #(.K0(C_CRR), .K1(C_CRG), .K2(C_CRB), .OFS(OFS_C)) u_cr (
    .clk(clk), .rst(rst), .a(px.r), .b(px.g), .c(px.b), .acc(acc_cr));
  // sof_in always restarts the frame, so it overrides any eol/eof the old counters would give
  always_comb begin
    acc_ok   = px.pix_valid && (px.sof_in || state == ACTIVE);
    cur_col  = px.sof_in ? '0 : col;
    cur_row  = px.sof_in ? '0 : row;
    last_col = cur_col == CW'(IMG_WIDTH - 1);
    at_eol   = !px.sof_in && last_col;
    at_eof   = at_eol && cur_row == RW'(IMG_HEIGHT - 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= WAIT_SOF;
      done         <= 1'b0;
      col          <= '0;
      row          <= '0;
      v            <= '0;
      ts           <= '0;
      te           <= '0;
      tf           <= '0;
      px.frame_err <= 1'b0;
      px.y_valid   <= 1'b0;
      px.sof       <= 1'b0;
      px.eol       <= 1'b0;
      px.eof       <= 1'b0;
      px.y         <= '0;
      px.cb        <= '0;
      px.cr        <= '0;
    end else begin
      px.frame_err <= px.pix_valid && (state == ACTIVE ? px.sof_in : !px.sof_in && done);
      if (acc_ok) begin
        col   <= last_col ? '0 : cur_col + 1'b1;
        row   <= last_col ? cur_row + 1'b1 : cur_row;
        state <= at_eof ? WAIT_SOF : ACTIVE;
        done  <= done | at_eof;
      end
      v          <= {v[0], acc_ok};
      ts         <= {ts[0], acc_ok && px.sof_in};
      te         <= {te[0], acc_ok && at_eol};
      tf         <= {tf[0], acc_ok && at_eof};
      px.y_valid <= v[1];
      px.sof     <= ts[1];
      px.eol     <= te[1];
      px.eof     <= tf[1];
      px.y       <= clamp8(acc_y, Y_MIN, Y_MAX);
      px.cb      <= clamp8(acc_cb, C_MIN, C_MAX);
      px.cr      <= clamp8(acc_cr, C_MIN, C_MAX);
    end
endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb_rgb_to_ycbcr: randomized self-checking bench against a frame-index reference model
module tb_rgb_to_ycbcr;
  localparam int W = 4;
  localparam int H = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  typedef struct {int due; logic [26:0] val;} exp_t;
  exp_t oq[$];
  int   eq[$];
  bit   m_active = 1'b0;
  bit   m_done = 1'b0;
  int   m_idx = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rgb_to_ycbcr_if bus();
  rgb_to_ycbcr #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .px(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] lim(input int s, input int lo, input int hi);
    int v = s >>> 8;
    return 8'(v < lo ? lo : v > hi ? hi : v);
  endfunction
  task automatic model(input int r, input int g, input int b, input bit sof);
    bit   acc, err, eol, eof;
    exp_t e;
    acc = sof || m_active;
    err = m_active ? sof : (!sof && m_done);
    if (err) eq.push_back(cyc + 1);
    if (acc) begin
      if (sof) m_idx = 0;
      eol = !sof && (m_idx % W == W - 1);
      eof = !sof && (m_idx == W * H - 1);
      e.due = cyc + 3;
      e.val = {lim(66 * r + 129 * g + 25 * b + 4224, 16, 235),
               lim(-38 * r - 74 * g + 112 * b + 32896, 16, 240),
               lim(112 * r - 94 * g - 18 * b + 32896, 16, 240), sof, eol, eof};
      oq.push_back(e);
      m_idx++;
      m_active = !eof;
      if (eof) m_done = 1'b1;
    end
  endtask
  task automatic send(input int r, input int g, input int b, input bit sof);
    @(posedge clk);
    #1;
    bus.r = 8'(r);
    bus.g = 8'(g);
    bus.b = 8'(b);
    bus.sof_in = sof;
    bus.pix_valid = 1'b1;
    model(r, g, b, sof);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      bus.sof_in = 1'b0;
    end
  endtask
  task automatic rsend(input bit sof);
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), sof);
  endtask
  always @(negedge clk)
    if (rst) begin
      if (eq.size() != 0 && eq[0] <= cyc) begin
        check("frame_err", 32'(bus.frame_err), 1);
        void'(eq.pop_front());
      end else check("frame_err", 32'(bus.frame_err), 0);
      if (oq.size() != 0 && oq[0].due <= cyc) begin
        check("y_valid", 32'(bus.y_valid), 1);
        if (bus.y_valid) check("pixel", 32'({bus.y, bus.cb, bus.cr, bus.sof, bus.eol, bus.eof}), 32'(oq[0].val));
        void'(oq.pop_front());
      end else check("y_valid", 32'(bus.y_valid), 0);
    end
  initial begin
    bus.r = 8'd0;
    bus.g = 8'd0;
    bus.b = 8'd0;
    bus.pix_valid = 1'b0;
    bus.sof_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 32'({bus.y, bus.cb, bus.cr, bus.y_valid, bus.sof, bus.eol, bus.eof, bus.frame_err}), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) rsend(1'b0);
    send(255, 255, 255, 1'b1);
    send(0, 0, 0, 1'b0);
    send(255, 0, 0, 1'b0);
    send(0, 255, 0, 1'b0);
    send(0, 0, 255, 1'b0);
    repeat (3) rsend(1'b0);
    repeat (2) rsend(1'b0);
    repeat (3) begin
      rsend(1'b1);
      repeat (W * H - 1) rsend(1'b0);
    end
    rsend(1'b1);
    repeat (4) rsend(1'b0);
    rsend(1'b1);
    repeat (W * H - 1) rsend(1'b0);
    rsend(1'b1);
    repeat (W * H - 2) rsend(1'b0);
    rsend(1'b1);
    repeat (W * H - 1) rsend(1'b0);
    idle(6);
    send(10, 20, 30, 1'b1);
    send(40, 50, 60, 1'b0);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.sof_in = 1'b0;
    rst = 1'b0;
    oq.delete();
    eq.delete();
    m_active = 1'b0;
    m_done = 1'b0;
    m_idx = 0;
    #1 check("reset_flush", 32'({bus.y, bus.cb, bus.cr, bus.y_valid, bus.sof, bus.eol, bus.eof, bus.frame_err}), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) rsend(1'b0);
    rsend(1'b1);
    repeat (W * H - 1) rsend(1'b0);
    idle(6);
    check("drain_pixels", 32'(oq.size()), 0);
    check("drain_errs", 32'(eq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
